// File: rtl/word_align_pkg.sv
// rtl/word_align_pkg.sv - shared state encoding and widths for the word aligner
// Contents: align_state_t (IDLE/SEARCH/VERIFY/LOCKED), byte/offset/counter widths,
//           next_offset() helper for the wrapping 3-bit shift offset.
package word_align_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_VERIFY = 2'd2,
        ST_LOCKED = 2'd3
    } align_state_t;

    localparam int BYTE_W         = 8;
    localparam int HIST_W         = 2 * BYTE_W;
    localparam int OFFSET_W       = 3;
    localparam int RUN_CNT_W      = 4;
    localparam int RELOCK_CNT_W   = 8;
    localparam int SYNC_ERR_CNT_W = 16;

    // Offset advances 0..7 and wraps back to 0.
    function automatic logic [OFFSET_W-1:0] next_offset(input logic [OFFSET_W-1:0] off);
        return off + 1'b1;
    endfunction

endpackage

// File: rtl/byte_bit_shifter.sv
// rtl/byte_bit_shifter.sv - two-byte history and bit-offset byte selection
// Ports: clk160, rst (async, high) | data_in[7:0] raw byte, bit 7 first on the wire
//        bit_offset[2:0] shift applied | cand[7:0] byte starting bit_offset bits into prev
module byte_bit_shifter
    import word_align_pkg::*;
(
    input  logic                clk160,
    input  logic                rst,
    input  logic [BYTE_W-1:0]   data_in,
    input  logic [OFFSET_W-1:0] bit_offset,
    output logic [BYTE_W-1:0]   cand
);

    logic [BYTE_W-1:0] prev;
    logic [HIST_W-1:0] hist;
    logic [3:0]        msb_idx;

    always_ff @(posedge clk160 or posedge rst) begin
        if (rst) begin
            prev <= '0;
        end else begin
            prev <= data_in;
        end
    end

    // Oldest bit sits at hist[15]; offset k picks the byte that starts k bits later.
    assign hist    = {prev, data_in};
    assign msb_idx = 4'd15 - {1'b0, bit_offset};
    assign cand    = hist[msb_idx -: BYTE_W];

endmodule

// File: rtl/word_align_ctrl.sv
// rtl/word_align_ctrl.sv - sync-byte search, frame lock and aligned byte output
// Ports: clk160, rst (async, high) | data_in[7:0], delay_ready, align_enable, sync_word[7:0],
//        reset_counters | data_out[7:0], data_valid, sof, locked, bit_offset[2:0],
//        relock_count[7:0], sync_err_count[15:0]
// Macro WORD_ALIGN_SYNC_ERR_CNT_EN: enables the sync_err_count statistic (else tied to 0).
module word_align_ctrl
    import word_align_pkg::*;
#(
    parameter int FRAME_LEN    = 16,
    parameter int LOCK_COUNT   = 4,
    parameter int UNLOCK_COUNT = 3
) (
    input  logic                      clk160,
    input  logic                      rst,
    input  logic [BYTE_W-1:0]         data_in,
    input  logic                      delay_ready,
    input  logic                      align_enable,
    input  logic [BYTE_W-1:0]         sync_word,
    input  logic                      reset_counters,
    output logic [BYTE_W-1:0]         data_out,
    output logic                      data_valid,
    output logic                      sof,
    output logic                      locked,
    output logic [OFFSET_W-1:0]       bit_offset,
    output logic [RELOCK_CNT_W-1:0]   relock_count,
    output logic [SYNC_ERR_CNT_W-1:0] sync_err_count
);

    localparam int FP_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [FP_W-1:0]      FP_LAST       = FP_W'(FRAME_LEN - 1);
    localparam logic [RUN_CNT_W-1:0] LOCK_TARGET   = RUN_CNT_W'(LOCK_COUNT);
    localparam logic [RUN_CNT_W-1:0] UNLOCK_TARGET = RUN_CNT_W'(UNLOCK_COUNT);

    align_state_t         state;
    logic [FP_W-1:0]      frame_pos;
    logic [FP_W-1:0]      frame_pos_next;
    logic [FP_W-1:0]      win_cnt;
    logic [RUN_CNT_W-1:0] hit_cnt;
    logic [RUN_CNT_W-1:0] miss_cnt;
    logic [BYTE_W-1:0]    cand;
    logic                 run;
    logic                 match;
    logic                 at_frame_start;
    logic                 locked_miss;
    logic                 lock_lost;

    byte_bit_shifter u_shifter (
        .clk160     (clk160),
        .rst        (rst),
        .data_in    (data_in),
        .bit_offset (bit_offset),
        .cand       (cand)
    );

    assign run            = delay_ready && align_enable;
    assign match          = (cand == sync_word);
    assign at_frame_start = (frame_pos == '0);
    assign frame_pos_next = (frame_pos == FP_LAST) ? '0 : frame_pos + 1'b1;
    assign locked_miss    = run && (state == ST_LOCKED) && at_frame_start && !match;
    assign lock_lost      = locked_miss && ((miss_cnt + 1'b1) == UNLOCK_TARGET);

    always_ff @(posedge clk160 or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            bit_offset <= '0;
            frame_pos  <= '0;
            win_cnt    <= '0;
            hit_cnt    <= '0;
            miss_cnt   <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            sof        <= 1'b0;
            locked     <= 1'b0;
        end else begin
            // Outputs reflect the state before this edge, so the completing sync hit is not flagged.
            data_out   <= cand;
            data_valid <= (state == ST_LOCKED);
            locked     <= (state == ST_LOCKED);
            sof        <= (state == ST_LOCKED) && at_frame_start;

            if (!run) begin
                state      <= ST_IDLE;
                bit_offset <= '0;
                frame_pos  <= '0;
                win_cnt    <= '0;
                hit_cnt    <= '0;
                miss_cnt   <= '0;
            end else begin
                frame_pos <= frame_pos_next;
                case (state)
                    ST_IDLE: begin
                        state   <= ST_SEARCH;
                        win_cnt <= '0;
                    end
                    ST_SEARCH: begin
                        if (match) begin
                            // The matched byte defines frame position 0.
                            frame_pos <= FP_W'(1);
                            hit_cnt   <= RUN_CNT_W'(1);
                            miss_cnt  <= '0;
                            state     <= (LOCK_COUNT == 1) ? ST_LOCKED : ST_VERIFY;
                        end else if (win_cnt == FP_LAST) begin
                            win_cnt    <= '0;
                            bit_offset <= next_offset(bit_offset);
                        end else begin
                            win_cnt <= win_cnt + 1'b1;
                        end
                    end
                    ST_VERIFY: begin
                        if (at_frame_start) begin
                            if (match) begin
                                hit_cnt <= hit_cnt + 1'b1;
                                if ((hit_cnt + 1'b1) == LOCK_TARGET) begin
                                    state    <= ST_LOCKED;
                                    miss_cnt <= '0;
                                end
                            end else begin
                                state      <= ST_SEARCH;
                                win_cnt    <= '0;
                                bit_offset <= next_offset(bit_offset);
                            end
                        end
                    end
                    ST_LOCKED: begin
                        if (at_frame_start) begin
                            if (match) begin
                                miss_cnt <= '0;
                            end else if (lock_lost) begin
                                // Offset is kept: the link most likely slipped frame, not bit.
                                state    <= ST_SEARCH;
                                win_cnt  <= '0;
                                miss_cnt <= '0;
                            end else begin
                                miss_cnt <= miss_cnt + 1'b1;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk160 or posedge rst) begin
        if (rst) begin
            relock_count <= '0;
        end else if (reset_counters) begin
            relock_count <= '0;
        end else if (lock_lost && (relock_count != '1)) begin
            relock_count <= relock_count + 1'b1;
        end
    end

`ifdef WORD_ALIGN_SYNC_ERR_CNT_EN
    always_ff @(posedge clk160 or posedge rst) begin
        if (rst) begin
            sync_err_count <= '0;
        end else if (reset_counters) begin
            sync_err_count <= '0;
        end else if (locked_miss && (sync_err_count != '1)) begin
            sync_err_count <= sync_err_count + 1'b1;
        end
    end
`else
    assign sync_err_count = '0;
`endif

endmodule

// File: tb/tb_word_align_ctrl.sv
// tb/tb_word_align_ctrl.sv - self-checking bench for word_align_ctrl
module tb_word_align_ctrl;

    localparam int FRAME_LEN    = 16;
    localparam int LOCK_COUNT   = 4;
    localparam int UNLOCK_COUNT = 3;
    localparam logic [7:0] SYNC = 8'hBC;
`ifdef WORD_ALIGN_SYNC_ERR_CNT_EN
    localparam int SERR_ON = 1;
`else
    localparam int SERR_ON = 0;
`endif

    localparam int MD_OFF     = 10;
    localparam int MD_HUNT    = 20;
    localparam int MD_CONFIRM = 30;
    localparam int MD_SYNCED  = 40;

    logic        clk160 = 1'b0;
    logic        rst;
    logic [7:0]  data_in;
    logic        delay_ready;
    logic        align_enable;
    logic [7:0]  sync_word;
    logic        reset_counters;
    logic [7:0]  data_out;
    logic        data_valid;
    logic        sof;
    logic        locked;
    logic [2:0]  bit_offset;
    logic [7:0]  relock_count;
    logic [15:0] sync_err_count;

    int checks = 0;
    int failures = 0;
    bit check_en = 0;

    word_align_ctrl #(
        .FRAME_LEN    (FRAME_LEN),
        .LOCK_COUNT   (LOCK_COUNT),
        .UNLOCK_COUNT (UNLOCK_COUNT)
    ) dut (
        .clk160         (clk160),
        .rst            (rst),
        .data_in        (data_in),
        .delay_ready    (delay_ready),
        .align_enable   (align_enable),
        .sync_word      (sync_word),
        .reset_counters (reset_counters),
        .data_out       (data_out),
        .data_valid     (data_valid),
        .sof            (sof),
        .locked         (locked),
        .bit_offset     (bit_offset),
        .relock_count   (relock_count),
        .sync_err_count (sync_err_count)
    );

    always #5 clk160 = ~clk160;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- stream generator: serial bit queue, 3-bit lead-in ----------------
    bit   bq[$] = '{1'b0, 1'b0, 1'b0};
    int   byte_idx = 0;
    int   frame_no = 0;
    int   corrupt_left = 0;
    bit   no_sync = 0;

    task automatic push_stream_byte();
        logic [7:0] b;
        if (byte_idx == 0) begin
            if (no_sync) begin
                b = 8'h05;
            end else if (corrupt_left > 0) begin
                b = 8'h00;
                corrupt_left--;
            end else begin
                b = SYNC;
            end
        end else begin
            b = {4'h0, 4'((frame_no * 3 + byte_idx) % 16)};
        end
        for (int i = 7; i >= 0; i--) bq.push_back(b[i]);
        byte_idx = (byte_idx + 1) % FRAME_LEN;
        if (byte_idx == 0) frame_no++;
    endtask

    task automatic next_byte(output logic [7:0] b);
        while (bq.size() < 8) push_stream_byte();
        for (int i = 7; i >= 0; i--) b[i] = bq.pop_front();
    endtask

    task automatic step(input int n);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            @(negedge clk160);
            #1;
            next_byte(b);
            data_in = b;
        end
    endtask

    // ---------------- behavioural model ----------------
    int         m_mode = MD_OFF;
    int         m_off = 0, m_pos = 0, m_win = 0, m_hits = 0, m_misses = 0;
    int         m_relock = 0, m_serr = 0;
    logic [7:0] m_prev = 8'h00;
    int         exp_data = 0, exp_valid = 0, exp_sof = 0, exp_locked = 0;
    int         mh, mc, npos;
    bit         mhit, mrun, ev_relock, ev_serr;

    always @(posedge clk160 or posedge rst) begin
        if (rst) begin
            m_mode = MD_OFF; m_off = 0; m_pos = 0; m_win = 0; m_hits = 0; m_misses = 0;
            m_relock = 0; m_serr = 0; m_prev = 8'h00;
            exp_data = 0; exp_valid = 0; exp_sof = 0; exp_locked = 0;
        end else begin
            mh   = int'(m_prev) * 256 + int'(data_in);
            mc   = (mh >> (8 - m_off)) & 255;
            mhit = (mc == int'(sync_word));
            exp_data   = mc;
            exp_valid  = (m_mode == MD_SYNCED) ? 1 : 0;
            exp_locked = exp_valid;
            exp_sof    = (m_mode == MD_SYNCED && m_pos == 0) ? 1 : 0;
            ev_relock = 0;
            ev_serr   = 0;
            mrun = delay_ready && align_enable;
            if (!mrun) begin
                m_mode = MD_OFF; m_off = 0; m_pos = 0; m_win = 0; m_hits = 0; m_misses = 0;
            end else begin
                npos = (m_pos + 1) % FRAME_LEN;
                if (m_mode == MD_OFF) begin
                    m_mode = MD_HUNT;
                    m_win = 0;
                end else if (m_mode == MD_HUNT) begin
                    if (mhit) begin
                        npos = 1;
                        m_hits = 1;
                        m_misses = 0;
                        m_mode = (LOCK_COUNT == 1) ? MD_SYNCED : MD_CONFIRM;
                    end else begin
                        m_win++;
                        if (m_win == FRAME_LEN) begin
                            m_win = 0;
                            m_off = (m_off + 1) % 8;
                        end
                    end
                end else if (m_mode == MD_CONFIRM) begin
                    if (m_pos == 0) begin
                        if (mhit) begin
                            m_hits++;
                            if (m_hits >= LOCK_COUNT) begin
                                m_mode = MD_SYNCED;
                                m_misses = 0;
                            end
                        end else begin
                            m_mode = MD_HUNT;
                            m_win = 0;
                            m_off = (m_off + 1) % 8;
                        end
                    end
                end else begin
                    if (m_pos == 0) begin
                        if (mhit) begin
                            m_misses = 0;
                        end else begin
                            m_misses++;
                            ev_serr = 1;
                            if (m_misses == UNLOCK_COUNT) begin
                                m_mode = MD_HUNT;
                                m_win = 0;
                                m_misses = 0;
                                ev_relock = 1;
                            end
                        end
                    end
                end
                m_pos = npos;
            end
            if (reset_counters) begin
                m_relock = 0;
                m_serr = 0;
            end else begin
                if (ev_relock && m_relock < 255) m_relock++;
                if (SERR_ON == 1 && ev_serr && m_serr < 65535) m_serr++;
            end
            m_prev = data_in;
        end
    end

    always @(negedge clk160) begin
        if (check_en) begin
            check("data_out",       32'(data_out),       32'(exp_data));
            check("data_valid",     32'(data_valid),     32'(exp_valid));
            check("sof",            32'(sof),            32'(exp_sof));
            check("locked",         32'(locked),         32'(exp_locked));
            check("bit_offset",     32'(bit_offset),     32'(m_off));
            check("relock_count",   32'(relock_count),   32'(m_relock));
            check("sync_err_count", 32'(sync_err_count), 32'(m_serr));
        end
    end

    // ---------------- directed scenarios ----------------
    task automatic wait_lock(input string nm, input int limit);
        int n;
        n = 0;
        for (int i = 1; i <= 400; i++) begin
            step(1);
            if (locked === 1'b1) begin
                n = i;
                break;
            end
        end
        check(nm, 32'(n >= 1 && n <= limit), 32'd1);
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_data_out"},   32'(data_out),       32'd0);
        check({pfx, "_valid"},      32'(data_valid),     32'd0);
        check({pfx, "_sof"},        32'(sof),            32'd0);
        check({pfx, "_locked"},     32'(locked),         32'd0);
        check({pfx, "_offset"},     32'(bit_offset),     32'd0);
        check({pfx, "_relock"},     32'(relock_count),   32'd0);
        check({pfx, "_sync_err"},   32'(sync_err_count), 32'd0);
    endtask

    initial begin
        bit saw;
        rst = 1'b1; data_in = 8'h00; delay_ready = 1'b0; align_enable = 1'b0;
        sync_word = SYNC; reset_counters = 1'b0;
        step(3);
        rst = 1'b0;
        check_en = 1;
        check_reset_values("reset");

        // 1: 3-bit delayed stream locks at offset 3 with periodic sof on the sync byte
        delay_ready = 1'b1; align_enable = 1'b1;
        wait_lock("s1_lock_time", 178);
        check("s1_offset", 32'(bit_offset), 32'd3);
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (sof === 1'b1) break;
        end
        check("s1_sof_seen", 32'(sof), 32'd1);
        check("s1_sof_byte", 32'(data_out), 32'hBC);
        step(15);
        check("s1_no_sof_mid", 32'(sof), 32'd0);
        step(1);
        check("s1_sof_period", 32'(sof), 32'd1);
        check("s1_sof_byte2", 32'(data_out), 32'hBC);

        // 2: two corrupted syncs keep lock
        corrupt_left = 2;
        step(64);
        check("s2_locked", 32'(locked), 32'd1);
        check("s2_relock", 32'(relock_count), 32'd0);
        check("s2_sync_err", 32'(sync_err_count), 32'(SERR_ON * 2));

        // 3: three corrupted syncs drop lock, relock at the same offset
        corrupt_left = 3;
        saw = 0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            if (locked === 1'b0) begin
                saw = 1;
                break;
            end
        end
        check("s3_lock_dropped", 32'(saw), 32'd1);
        check("s3_relock", 32'(relock_count), 32'd1);
        wait_lock("s3_relock_time", 100);
        check("s3_offset", 32'(bit_offset), 32'd3);

        // 4: delay_ready falls while locked
        step(5);
        delay_ready = 1'b0;
        step(1);
        check("s4_valid_edge1", 32'(data_valid), 32'd1);
        check("s4_offset", 32'(bit_offset), 32'd0);
        step(1);
        check("s4_valid_edge2", 32'(data_valid), 32'd0);
        check("s4_locked", 32'(locked), 32'd0);
        delay_ready = 1'b1;
        wait_lock("s4_relock_time", 178);
        check("s4_offset_relock", 32'(bit_offset), 32'd3);

        // 5: no sync byte -> offset sweeps 0..7 every FRAME_LEN cycles and wraps
        no_sync = 1;
        align_enable = 1'b0;
        step(4);
        align_enable = 1'b1;
        saw = 0;
        for (int k = 1; k <= 160; k++) begin
            step(1);
            if (locked !== 1'b0) saw = 1;
            if (k % 16 == 8) check($sformatf("s5_offset_w%0d", k / 16), 32'(bit_offset), 32'((k / 16) % 8));
        end
        check("s5_never_locked", 32'(saw), 32'd0);

        // 6: reset mid-VERIFY, then reset_counters coincident with sync errors
        no_sync = 0;
        saw = 0;
        for (int i = 0; i < 400; i++) begin
            step(1);
            if (m_mode == MD_CONFIRM) begin
                saw = 1;
                break;
            end
        end
        check("s6_reached_verify", 32'(saw), 32'd1);
        rst = 1'b1;
        step(1);
        check_reset_values("s6_rst");
        rst = 1'b0;
        wait_lock("s6_lock_time", 178);
        step(20);
        corrupt_left = 3;
        saw = 0;
        for (int i = 0; i < 100; i++) begin
            reset_counters = (m_mode == MD_SYNCED && m_pos == 0);
            step(1);
            if (locked === 1'b0) saw = 1;
        end
        reset_counters = 1'b0;
        check("s6_lock_dropped", 32'(saw), 32'd1);
        check("s6_relock_cleared", 32'(relock_count), 32'd0);
        check("s6_sync_err_cleared", 32'(sync_err_count), 32'd0);
        step(2);

        check_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
